seri_alici_verici: RTL

SERI_ALICI_VERICI -- requirements
Module: seri_alici_verici

---
 rtl/seri_pkg.sv | 14 +
 rtl/seri_verici.sv | 99 +++++++++
 rtl/seri_alici_verici.sv | 134 +++++++++++++
 3 files changed

// File: rtl/seri_pkg.sv
// Shared state encoding and line-level default for the serial transceiver.
package seri_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } seri_state_e;

    localparam logic IDLE_LVL_DEF = 1'b1;

endpackage

// File: rtl/seri_verici.sv
// Serial transmitter: start bit, DATA_W bits LSB first, optional even parity, stop bit.
// Parity is inserted only when SERI_ALICI_VERICI_PARITY_EN is defined.
module seri_verici
    import seri_pkg::*;
#(
    parameter int   DATA_W   = 3,
    parameter logic IDLE_LVL = IDLE_LVL_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tx_start,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx,
    output logic              tx_busy
);

    localparam int              CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    seri_state_e       state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
`ifdef SERI_ALICI_VERICI_PARITY_EN
    logic              par_q, par_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
`ifdef SERI_ALICI_VERICI_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
`ifdef SERI_ALICI_VERICI_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Line level and busy are decoded from state so reset forces idle immediately.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
`ifdef SERI_ALICI_VERICI_PARITY_EN
        par_d   = par_q;
`endif
        tx      = IDLE_LVL;
        tx_busy = 1'b1;
        case (state_q)
            IDLE: begin
                tx_busy = 1'b0;
                if (tx_start) begin
                    shift_d = tx_data;
                    cnt_d   = '0;
`ifdef SERI_ALICI_VERICI_PARITY_EN
                    par_d   = ^tx_data;
`endif
                    state_d = START;
                end
            end
            START: begin
                tx      = ~IDLE_LVL;
                state_d = DATA;
            end
            DATA: begin
                tx      = shift_q[0];
                shift_d = shift_q >> 1;
                if (cnt_q == LAST_BIT) begin
`ifdef SERI_ALICI_VERICI_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef SERI_ALICI_VERICI_PARITY_EN
            PARITY: begin
                tx      = par_q;
                state_d = STOP;
            end
`endif
            STOP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/seri_alici_verici.sv
// Serial transceiver top: transmitter sub-module plus the receiver FSM.
// Define SERI_ALICI_VERICI_PARITY_EN to add an even-parity bit to every frame.
module seri_alici_verici
    import seri_pkg::*;
#(
    parameter int   DATA_W   = 3,
    parameter logic IDLE_LVL = IDLE_LVL_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    input  logic              rx_en,
    input  logic              tx_start,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx,
    output logic              tx_busy,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_err
);

    localparam int              CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    seri_verici #(
        .DATA_W   (DATA_W),
        .IDLE_LVL (IDLE_LVL)
    ) u_verici (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx       (tx),
        .tx_busy  (tx_busy)
    );

    seri_state_e       rx_state_q, rx_state_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              rx_err_q, rx_err_d;
    logic              frame_ok;
`ifdef SERI_ALICI_VERICI_PARITY_EN
    logic              rx_par_err_q, rx_par_err_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q   <= IDLE;
            rx_shift_q   <= '0;
            rx_cnt_q     <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            rx_err_q     <= 1'b0;
`ifdef SERI_ALICI_VERICI_PARITY_EN
            rx_par_err_q <= 1'b0;
`endif
        end else begin
            rx_state_q   <= rx_state_d;
            rx_shift_q   <= rx_shift_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            rx_err_q     <= rx_err_d;
`ifdef SERI_ALICI_VERICI_PARITY_EN
            rx_par_err_q <= rx_par_err_d;
`endif
        end
    end

    // The start bit is consumed in IDLE, so the receiver never visits START.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_shift_d = rx_shift_q;
        rx_cnt_d   = rx_cnt_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_err_d   = 1'b0;
`ifdef SERI_ALICI_VERICI_PARITY_EN
        rx_par_err_d = rx_par_err_q;
        frame_ok     = (rx == IDLE_LVL) && !rx_par_err_q;
`else
        frame_ok     = (rx == IDLE_LVL);
`endif
        if (!rx_en) begin
            rx_state_d = IDLE;
        end else begin
            case (rx_state_q)
                IDLE: begin
                    if (rx == ~IDLE_LVL) begin
                        rx_cnt_d   = '0;
                        rx_state_d = DATA;
                    end
                end
                DATA: begin
                    rx_shift_d = (rx_shift_q >> 1) | (DATA_W'(rx) << (DATA_W - 1));
                    if (rx_cnt_q == LAST_BIT) begin
`ifdef SERI_ALICI_VERICI_PARITY_EN
                        rx_state_d = PARITY;
`else
                        rx_state_d = STOP;
`endif
                    end else begin
                        rx_cnt_d = rx_cnt_q + CNT_W'(1);
                    end
                end
`ifdef SERI_ALICI_VERICI_PARITY_EN
                PARITY: begin
                    rx_par_err_d = rx ^ (^rx_shift_q);
                    rx_state_d   = STOP;
                end
`endif
                STOP: begin
                    if (frame_ok) begin
                        rx_data_d  = rx_shift_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        rx_err_d = 1'b1;
                    end
                    rx_state_d = IDLE;
                end
                default: begin
                    rx_state_d = IDLE;
                end
            endcase
        end
    end

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rx_err   = rx_err_q;

endmodule
